// File: rtl/ws281x_pkg.sv
// Shared types and constants for the WS281x receive path.
`timescale 1ns/1ps
package ws281x_pkg;
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_e;

    localparam int         PIXEL_BITS = 24;
    localparam logic [7:0] HI_CNT_MAX = 8'hff;
endpackage

// File: rtl/ws281x_rx_sync.sv
// Two-flop synchronizer for the serial line plus registered rise/fall pulses.
// Pulses appear 3 clocks after a din_i transition; lvl_o is the delayed level.
`timescale 1ns/1ps
module ws281x_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, d_q, rise_q, fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            d_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            d_q    <= s2_q;
            rise_q <= s2_q & ~d_q;
            fall_q <= ~s2_q & d_q;
        end
    end

    assign lvl_o  = d_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/ws281x_rx.sv
// WS281x serial receiver: classifies pulse widths, assembles GRB pixels into
// pixel-RAM writes and flags end of frame on the latch gap.
`timescale 1ns/1ps
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned MIN_HIGH_CNT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  din_i,
    input  logic [7:0]            thr_cnt_i,
    input  logic [15:0]           rst_cnt_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic                  frame_done_o,
    output logic [ADDR_WIDTH:0]   pix_cnt_o,
    output logic                  err_o
);
    localparam int unsigned        PIX_MAX_I = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PIX_MAX  = PIX_MAX_I[ADDR_WIDTH:0];
    localparam logic [4:0]         LAST_BIT  = 5'(PIXEL_BITS - 1);

    logic lvl, rise, fall;

    ws281x_rx_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (din_i),
        .lvl_o  (lvl),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e                state_q;
    logic [7:0]            hi_cnt_q;
    logic [15:0]           lo_cnt_q;
    logic [4:0]            bit_cnt_q;
    logic [23:0]           shreg_q;
    logic [ADDR_WIDTH:0]   wr_cnt_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_en_q;
    logic [31:0]           wr_data_q;
    logic                  frame_done_q;
    logic [ADDR_WIDTH:0]   pix_cnt_q;
    logic                  err_q;

    logic [15:0] rst_thr;
    logic [15:0] lo_inc;
    logic        bit_val;
    logic [23:0] shreg_d;

    // A zero latch gap would end every frame instantly; treat it as one clock.
    assign rst_thr = (rst_cnt_i == 16'd0) ? 16'd1 : rst_cnt_i;
    assign lo_inc  = (lo_cnt_q == 16'hffff) ? lo_cnt_q : lo_cnt_q + 16'd1;
    assign bit_val = hi_cnt_q > thr_cnt_i;
    assign shreg_d = {shreg_q[22:0], bit_val};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= SYNC;
            hi_cnt_q     <= 8'd0;
            lo_cnt_q     <= 16'd0;
            bit_cnt_q    <= 5'd0;
            shreg_q      <= 24'd0;
            wr_cnt_q     <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 32'd0;
            frame_done_q <= 1'b0;
            pix_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (lvl) begin
                        lo_cnt_q <= 16'd0;
                    end else begin
                        lo_cnt_q <= lo_inc;
                        if (lo_inc >= rst_thr) state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state_q   <= HIGH;
                        hi_cnt_q  <= 8'd1;
                        bit_cnt_q <= 5'd0;
                        wr_cnt_q  <= '0;
                        err_q     <= 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (hi_cnt_q < 8'(MIN_HIGH_CNT)) begin
                            err_q     <= 1'b1;
                            state_q   <= SYNC;
                            lo_cnt_q  <= 16'd0;
                            bit_cnt_q <= 5'd0;
                        end else begin
                            shreg_q  <= shreg_d;
                            lo_cnt_q <= 16'd1;
                            state_q  <= LOW;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= 5'd0;
                                // RAM is full: drop the pixel but remember it happened.
                                if (wr_cnt_q < PIX_MAX) begin
                                    wr_en_q   <= 1'b1;
                                    wr_data_q <= {8'h00, shreg_d};
                                    wr_addr_q <= wr_cnt_q[ADDR_WIDTH-1:0];
                                    wr_cnt_q  <= wr_cnt_q + 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end else if (hi_cnt_q == HI_CNT_MAX) begin
                        err_q     <= 1'b1;
                        state_q   <= SYNC;
                        lo_cnt_q  <= 16'd0;
                        bit_cnt_q <= 5'd0;
                    end else begin
                        hi_cnt_q <= hi_cnt_q + 8'd1;
                    end
                end
                LOW: begin
                    // End of frame takes priority over a coincident rise.
                    if (lo_cnt_q >= rst_thr) begin
                        if (bit_cnt_q != 5'd0) err_q <= 1'b1;
                        frame_done_q <= 1'b1;
                        pix_cnt_q    <= wr_cnt_q;
                        wr_cnt_q     <= '0;
                        bit_cnt_q    <= 5'd0;
                        state_q      <= IDLE;
                    end else if (rise) begin
                        state_q  <= HIGH;
                        hi_cnt_q <= 8'd1;
                    end else begin
                        lo_cnt_q <= lo_inc;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = frame_done_q;
    assign pix_cnt_o    = pix_cnt_q;
    assign err_o        = err_q;
endmodule

// File: doc/ws281x_rx.md
Name: ws281x_rx

Overview:
- Single-wire WS281x (NeoPixel) receiver: the inverse of the ws281x_ctrl/bit-encoder transmit path.
- Samples the serial data line and classifies each high pulse as 0 or 1 by its width.
- Assembles MSB-first 24-bit GRB pixels and writes one 32-bit word per pixel into the same pixel RAM format ws281x_ctrl reads.
- Detects the latch/reset gap as end of frame; used for chaining boards and loopback self-test.

Parameters:
- ADDR_WIDTH, 6, pixel RAM address width; capacity 2^ADDR_WIDTH pixels.
- MIN_HIGH_CNT, 2, high pulses shorter than this many clocks are glitches.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- din_i  in  1  WS281x serial line, asynchronous to clk_i
- thr_cnt_i  in  8  high-time threshold in clocks; high time > thr => bit 1, else bit 0
- rst_cnt_i  in  16  low time in clocks that terminates a frame (latch gap)
- wr_en_o  out  1  pixel RAM write strobe, one cycle per pixel
- wr_addr_o  out  ADDR_WIDTH  pixel RAM write address
- wr_data_o  out  32  {8'h00, G[7:0], R[7:0], B[7:0]}
- frame_done_o  out  1  one-cycle pulse at end of frame
- pix_cnt_o  out  ADDR_WIDTH+1  pixels written in last completed frame; held until next frame_done_o
- err_o  out  1  sticky frame error; cleared on first rising edge of next frame

Behaviour:
- Reset values: all outputs 0; state SYNC; counters, address and shift register 0; synchronizer flops 0.
- Input path: 2-FF synchronizer plus one edge-detect flop. Rise/fall flags are valid 3 clocks after a din_i transition.
- hi_cnt (8b) and lo_cnt (16b) both saturate.

States:
- SYNC: count consecutive low cycles; on reaching rst_cnt_i go to IDLE; any high restarts the count. Prevents locking onto a frame mid-stream.
- IDLE: on rise -> HIGH, hi_cnt=1, bit_cnt=0, wr_addr=0, err_o cleared.
- HIGH: hi_cnt++ each cycle.
  - If hi_cnt reaches 255 (stuck high): err_o=1 -> SYNC, partial pixel discarded.
  - On fall with hi_cnt < MIN_HIGH_CNT: glitch, err_o=1 -> SYNC.
  - Otherwise on fall: shift in bit (hi_cnt > thr_cnt_i), bit_cnt++, lo_cnt=1 -> LOW.
- LOW: lo_cnt++.
  - On rise -> HIGH, hi_cnt=1.
  - When lo_cnt reaches rst_cnt_i: end of frame. If bit_cnt != 0, set err_o and discard the partial pixel. Pulse frame_done_o, load pix_cnt_o, reset wr_addr to 0 -> IDLE.

Pixel write:
- When the 24th bit is shifted in, wr_en_o=1 on the next cycle with wr_data_o={8'h00, shreg} and the current wr_addr_o.
- wr_addr increments after the write; bit_cnt returns to 0.
- wr_data_o and wr_addr_o hold between strobes.

Overflow:
- After 2^ADDR_WIDTH pixels, further complete pixels are dropped (no wr_en_o) and err_o=1.
- pix_cnt_o saturates at 2^ADDR_WIDTH.

Edge cases:
- rst_cnt_i=0 is treated as 1.
- A rise in the same cycle lo_cnt reaches rst_cnt_i: end-of-frame wins, then IDLE accepts the rise on the next detection.
- rst_i mid-frame: immediate return to reset values and SYNC, no write or frame_done_o.
- A frame with zero complete pixels still pulses frame_done_o with pix_cnt_o=0.

Decomposition:
- ws281x_pkg holds:
  - state enum (SYNC, IDLE, HIGH, LOW)
  - PIXEL_BITS=24
  - HI_CNT_MAX=8'hff
- One sub-module: ws281x_rx_sync (2-FF synchronizer plus rise/fall pulse generation, reset to 0).

Test Plan:
Common setup: 5 ns clock; thr_cnt_i=8; rst_cnt_i=64; bit 0 = 4 clocks high / 12 low; bit 1 = 12 high / 4 low; din_i held low 70 clocks after reset.
- Single pixel 24'hAACCCC then 80-clock low -> wr_en_o once, wr_addr_o=0, wr_data_o=32'h00aa_cccc; frame_done_o once; pix_cnt_o=1; err_o=0.
- Three pixels 24'hAADDDD, 24'h000000, 24'hFFFFFF -> writes at addresses 0,1,2 with matching data; pix_cnt_o=3; next frame restarts at address 0.
- 30 bits then latch gap -> one write (first 24 bits), frame_done_o, pix_cnt_o=1, err_o=1; err_o clears at next frame's first rise.
- 1-clock high glitch mid-pixel -> err_o=1, no write, no frame_done_o; next clean frame after gap decodes correctly.
- 65 pixels with ADDR_WIDTH=6 -> 64 writes (addresses 0..63), 65th dropped, pix_cnt_o=64, err_o=1.
- rst_i asserted during the 12th bit -> all outputs 0 within the same cycle; no spurious wr_en_o; after rst_i release, din_i must stay low for 64 clocks before a frame decodes.
